// File: rtl/wb_cmd_master_if.sv
// wb_cmd_master_if: command/response ports and Wishbone classic signals of wb_cmd_master.
interface wb_cmd_master_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_we;
  logic [AW-1:0] i_cmd_adr;
  logic [DW-1:0] i_cmd_data;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [DW-1:0] o_rsp_data;
  logic          o_rsp_err;
  logic          o_wb_cyc;
  logic          o_wb_stb;
  logic          o_wb_we;
  logic [3:0]    o_wb_sel;
  logic [AW-1:0] o_wb_adr;
  logic [DW-1:0] o_wb_data;
  logic          i_wb_ack;
  logic [DW-1:0] i_wb_data;
  modport master (
    input  i_cmd_valid, i_cmd_we, i_cmd_adr, i_cmd_data, i_rsp_ready, i_wb_ack, i_wb_data,
    output o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr, o_wb_data
  );
  modport slave (
    output i_cmd_valid, i_cmd_we, i_cmd_adr, i_cmd_data, i_rsp_ready, i_wb_ack, i_wb_data,
    input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr, o_wb_data
  );
endinterface

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: FIFO-buffered Wishbone classic single-transfer initiator with ack timeout.
module wb_cmd_master #(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  wb_cmd_master_if.master bus,
  output logic            o_busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + AW + DW;
  typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;
  state_t        r_state, w_state;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [EW-1:0] w_head;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_tmo, w_tmo;
  logic          r_stb, w_stb, r_we, w_we;
  logic          r_rsp_valid, w_rsp_valid, r_rsp_err, w_rsp_err;
  logic [AW-1:0] r_adr, w_adr;
  logic [DW-1:0] r_wdat, w_wdat, r_rdat, w_rdat;
  logic          w_push, w_pop, w_empty;
  assign bus.o_cmd_ready = r_count != CW'(FIFO_DEPTH);
  assign w_empty         = r_count == '0;
  assign w_push          = bus.i_cmd_valid && bus.o_cmd_ready;
  assign w_pop           = r_state == IDLE && !w_empty;
  assign w_head          = r_mem[r_rd_ptr];
  assign o_busy          = r_state != IDLE || !w_empty;
  assign bus.o_wb_cyc    = r_stb;
  assign bus.o_wb_stb    = r_stb;
  assign bus.o_wb_we     = r_we;
  assign bus.o_wb_sel    = 4'hF;
  assign bus.o_wb_adr    = r_adr;
  assign bus.o_wb_data   = r_wdat;
  assign bus.o_rsp_valid = r_rsp_valid;
  assign bus.o_rsp_data  = r_rdat;
  assign bus.o_rsp_err   = r_rsp_err;
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wr_ptr] <= {bus.i_cmd_we, bus.i_cmd_adr, bus.i_cmd_data};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_push);
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_tmo       <= '0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_wdat      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rdat      <= '0;
    end else begin
      r_state     <= w_state;
      r_tmo       <= w_tmo;
      r_stb       <= w_stb;
      r_we        <= w_we;
      r_adr       <= w_adr;
      r_wdat      <= w_wdat;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rdat      <= w_rdat;
    end
  // Ack is tested before the timeout so a last-cycle ack still completes cleanly.
  always_comb begin
    w_state     = r_state;
    w_tmo       = r_tmo;
    w_stb       = r_stb;
    w_we        = r_we;
    w_adr       = r_adr;
    w_wdat      = r_wdat;
    w_rsp_valid = r_rsp_valid;
    w_rsp_err   = r_rsp_err;
    w_rdat      = r_rdat;
    if (w_pop) begin
      w_state               = BUS;
      w_stb                 = 1'b1;
      w_tmo                 = '0;
      {w_we, w_adr, w_wdat} = w_head;
    end else if (r_state == BUS && bus.i_wb_ack) begin
      w_state     = RSP;
      w_stb       = 1'b0;
      w_rsp_valid = 1'b1;
      w_rsp_err   = 1'b0;
      w_rdat      = r_we ? '0 : bus.i_wb_data;
    end else if (r_state == BUS && r_tmo == 8'(TIMEOUT - 1)) begin
      w_state     = RSP;
      w_stb       = 1'b0;
      w_rsp_valid = 1'b1;
      w_rsp_err   = 1'b1;
      w_rdat      = '0;
    end else if (r_state == BUS) begin
      w_tmo = r_tmo + 8'd1;
    end else if (r_state == RSP && bus.i_rsp_ready) begin
      w_state     = IDLE;
      w_rsp_valid = 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed stimulus with a response scoreboard and a Wishbone slave model.
module tb_wb_cmd_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  wb_cmd_master_if #(.AW(16), .DW(32)) bus ();
  wb_cmd_master #(.AW(16), .DW(32), .FIFO_DEPTH(4), .TIMEOUT(8)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus),
    .o_busy (busy)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic err; logic [31:0] data;} rsp_t;
  rsp_t        sb[$];
  rsp_t        exp_r;
  int          n_checks = 0, n_fail = 0;
  int          lat = 1, slv_w = 0;
  bit          stall = 0, stray = 0;
  logic [31:0] mem [logic [15:0]];
  int          cur_len = 0, last_len = 0, pulses = 0, p0 = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask
  task automatic sb_add(input logic err, input logic [31:0] data);
    sb.push_back({err, data});
  endtask
  task automatic push(input logic we, input logic [15:0] adr, input logic [31:0] data);
    @(negedge clk);
    for (int t = 0; t < 100 && !bus.o_cmd_ready; t++) @(negedge clk);
    check("push_ready", bus.o_cmd_ready, 1);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_we    = we;
    bus.i_cmd_adr   = adr;
    bus.i_cmd_data  = data;
    @(posedge clk);
    #1 bus.i_cmd_valid = 1'b0;
  endtask
  task automatic wait_rsp();
    for (int t = 0; t < 100 && !bus.o_rsp_valid; t++) begin
      @(posedge clk);
      #2;
    end
    check("rsp_wait", bus.o_rsp_valid, 1);
  endtask
  task automatic wait_idle();
    for (int t = 0; t < 200 && (busy || bus.o_rsp_valid); t++) begin
      @(posedge clk);
      #2;
    end
    check("idle_wait", busy || bus.o_rsp_valid, 0);
  endtask
  // Slave: acks once stb has been seen for `lat` edges; toggles a stray ack when asked.
  initial begin
    bus.i_wb_ack  = 1'b0;
    bus.i_wb_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus.o_wb_stb) begin
        slv_w = 0;
        bus.i_wb_ack = stray ? !bus.i_wb_ack : 1'b0;
      end else if (bus.i_wb_ack) bus.i_wb_ack = 1'b0;
      else begin
        slv_w++;
        if (!stall && slv_w >= lat) begin
          bus.i_wb_ack = 1'b1;
          if (bus.o_wb_we) mem[bus.o_wb_adr] = bus.o_wb_data;
          bus.i_wb_data = mem.exists(bus.o_wb_adr) ? mem[bus.o_wb_adr] : {16'hC0DE, bus.o_wb_adr};
        end
      end
    end
  end
  always @(negedge clk)
    if (rst_n && bus.o_rsp_valid && bus.i_rsp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got data %0h err %0b, required no response", bus.o_rsp_data, bus.o_rsp_err);
      end else begin
        exp_r = sb.pop_front();
        check("rsp_err", bus.o_rsp_err, exp_r.err);
        check("rsp_data", bus.o_rsp_data, exp_r.data);
      end
    end
  always @(negedge clk)
    if (bus.o_wb_stb) begin
      if (cur_len == 0) begin
        check("wb_sel", bus.o_wb_sel, 4'hF);
        check("wb_cyc", bus.o_wb_cyc, 1);
      end
      cur_len++;
    end else if (cur_len != 0) begin
      last_len = cur_len;
      pulses++;
      cur_len = 0;
    end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [15:0] a;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_we    = 1'b0;
    bus.i_cmd_adr   = '0;
    bus.i_cmd_data  = '0;
    bus.i_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_stb", bus.o_wb_stb, 0);
    check("rst_cyc", bus.o_wb_cyc, 0);
    check("rst_we", bus.o_wb_we, 0);
    check("rst_adr", bus.o_wb_adr, 0);
    check("rst_wdata", bus.o_wb_data, 0);
    check("rst_rsp_valid", bus.o_rsp_valid, 0);
    check("rst_rsp_err", bus.o_rsp_err, 0);
    check("rst_rsp_data", bus.o_rsp_data, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", bus.o_cmd_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    push(1'b1, 16'h0010, 32'hDEADBEEF);
    sb_add(1'b0, 32'h0);
    @(posedge clk);
    #2;
    check("wr_stb_latency", bus.o_wb_stb, 1);
    check("wr_we", bus.o_wb_we, 1);
    check("wr_adr", bus.o_wb_adr, 16'h0010);
    check("wr_data", bus.o_wb_data, 32'hDEADBEEF);
    @(posedge clk);
    #2;
    check("wr_stb_drop", bus.o_wb_stb, 0);
    check("wr_rsp_latency", bus.o_rsp_valid, 1);
    wait_idle();
    push(1'b0, 16'h0010, 32'h0);
    sb_add(1'b0, 32'hDEADBEEF);
    @(posedge clk);
    #2;
    check("rd_stb_latency", bus.o_wb_stb, 1);
    check("rd_we", bus.o_wb_we, 0);
    @(posedge clk);
    #2;
    check("rd_rsp_latency", bus.o_rsp_valid, 1);
    wait_idle();
    stall = 1;
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      a = 16'(32 + i);
      push(1'b0, a, 32'h0);
      sb_add(1'b0, {16'hC0DE, a});
    end
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_adr   = 16'h00FF;
    @(posedge clk);
    #2;
    check("full_ready", bus.o_cmd_ready, 0);
    check("full_one_on_bus", bus.o_wb_stb, 1);
    bus.i_cmd_valid = 1'b0;
    stall = 0;
    wait_idle();
    check("full_drain_pulses", pulses - p0, 5);
    check("full_drain_sb", sb.size(), 0);
    stall = 1;
    push(1'b0, 16'h0030, 32'h0);
    sb_add(1'b1, 32'h0);
    push(1'b0, 16'h0031, 32'h0);
    sb_add(1'b0, 32'hC0DE0031);
    wait_rsp();
    @(negedge clk);
    #1;
    check("tmo_stb_len", last_len, 8);
    stall = 0;
    wait_idle();
    lat = 8;
    push(1'b0, 16'h0040, 32'h0);
    sb_add(1'b0, 32'hC0DE0040);
    wait_idle();
    check("ack_on_tmo_len", last_len, 8);
    lat = 1;
    bus.i_rsp_ready = 1'b0;
    push(1'b0, 16'h0050, 32'h0);
    sb_add(1'b0, 32'hC0DE0050);
    push(1'b0, 16'h0051, 32'h0);
    sb_add(1'b0, 32'hC0DE0051);
    wait_rsp();
    stray = 1;
    repeat (10) begin
      @(posedge clk);
      #2;
      check("bp_valid", bus.o_rsp_valid, 1);
      check("bp_data", bus.o_rsp_data, 32'hC0DE0050);
      check("bp_err", bus.o_rsp_err, 0);
      check("bp_no_stb", bus.o_wb_stb, 0);
    end
    stray = 0;
    bus.i_rsp_ready = 1'b1;
    @(posedge clk);
    #2;
    check("bp_valid_drop", bus.o_rsp_valid, 0);
    check("bp_idle_gap", bus.o_wb_stb, 0);
    @(posedge clk);
    #2;
    check("bp_next_stb", bus.o_wb_stb, 1);
    wait_idle();
    stall = 1;
    push(1'b0, 16'h0060, 32'h0);
    push(1'b0, 16'h0061, 32'h0);
    push(1'b0, 16'h0062, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_stb", bus.o_wb_stb, 0);
    check("arst_cyc", bus.o_wb_cyc, 0);
    check("arst_cmd_ready", bus.o_cmd_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_adr", bus.o_wb_adr, 0);
    check("arst_rsp_valid", bus.o_rsp_valid, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    stall = 0;
    p0 = pulses;
    repeat (20) @(posedge clk);
    #2;
    check("post_rst_no_stb", pulses - p0, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_sb", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
